// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 8-bit binary to 3-digit packed BCD converter.
// Uses shift-add-3 (double dabble), one iteration per clock, with a
// start/busy/done handshake. All outputs come straight from flops.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] scratch_q, scratch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [11:0] adjusted;
    logic [19:0] shifted;

    // Add 3 to a BCD nibble that is 5 or more, so the following shift carries
    // correctly into the next decimal digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // Next-state and datapath: one double-dabble iteration per SHIFT cycle;
    // a request is accepted from either IDLE or DONE.
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        adjusted  = {add3(scratch_q[19:16]), add3(scratch_q[15:12]), add3(scratch_q[11:8])};
        shifted   = {adjusted[10:0], scratch_q[7:0], 1'b0};

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SHIFT;
                    scratch_d = {12'h000, bin};
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    bcd_d   = shifted[19:8];
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; reset aborts any
    // conversion in flight and clears the previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            scratch_q <= 20'h00000;
            cnt_q     <= 3'd0;
            bcd_q     <= 12'h000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: self-checking bench for bin2bcd_seq. Expected BCD values
// come from a decimal-split reference model; inputs are driven and outputs
// sampled on the falling clock edge.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int tests_run;
    int tests_failed;

    bin2bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits of the value, packed as BCD nibbles.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Drive one start pulse and measure the response: cycles from start edge
    // to done, number of busy cycles before done, and bcd during done.
    // lat is left at 99 when done never arrives within the bound.
    task automatic run_conversion(input logic [7:0] v, output int lat,
                                  output int busy_cnt, output logic [11:0] res,
                                  output logic busy_at_done);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        lat          = done ? cycles : 99;
        res          = bcd;
        busy_at_done = busy;
    endtask

    // Power-on reset and asynchronous reset between edges.
    task automatic test_reset();
        int lat, bc;
        logic [11:0] res;
        logic bd;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'h00;
        #23;
        tests_run++;
        if ({busy, done, bcd} !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_init: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        run_conversion(8'd255, lat, bc, res, bd);
        tests_run++;
        if (res !== 12'h255) begin
            tests_failed++;
            $display("[TB] FAIL reset_preload: bcd=%h expected 255", res);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, bcd} !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed values with literal expected results.
    task automatic test_directed();
        logic [7:0]  vals [5] = '{8'd0, 8'd9, 8'd99, 8'd100, 8'd255};
        logic [11:0] exps [5] = '{12'h000, 12'h009, 12'h099, 12'h100, 12'h255};
        int lat, bc;
        logic [11:0] res;
        logic bd;
        for (int i = 0; i < 5; i++) begin
            run_conversion(vals[i], lat, bc, res, bd);
            tests_run++;
            if (lat !== 8 || res !== exps[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_%0d: latency=%0d bcd=%h expected latency 8 bcd %h",
                         vals[i], lat, res, exps[i]);
            end
        end
    endtask

    // Every input value, including busy width and the one-cycle done pulse.
    task automatic test_sweep();
        int lat, bc;
        logic [11:0] res;
        logic bd;
        for (int v = 0; v < 256; v++) begin
            run_conversion(8'(v), lat, bc, res, bd);
            tests_run++;
            if (lat !== 8 || bc !== 8 || bd !== 1'b0 || res !== ref_bcd(v)) begin
                tests_failed++;
                $display("[TB] FAIL sweep_%0d: latency=%0d busy_cycles=%0d busy_at_done=%b bcd=%h expected 8 8 0 %h",
                         v, lat, bc, bd, res, ref_bcd(v));
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL sweep_pulse_%0d: done=%b one cycle after done, expected 0", v, done);
            end
        end
    endtask

    // Random values against the reference model.
    task automatic test_random();
        int lat, bc;
        logic [11:0] res;
        logic bd;
        logic [7:0] v;
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom_range(255, 0));
            run_conversion(v, lat, bc, res, bd);
            tests_run++;
            if (lat !== 8 || res !== ref_bcd(int'(v))) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: latency=%0d bcd=%h expected 8 %h", v, lat, res, ref_bcd(int'(v)));
            end
        end
    endtask

    // A second start during SHIFT must be ignored entirely.
    task automatic test_start_while_busy();
        int dones;
        logic [11:0] res;
        dones = 0;
        res   = 12'hfff;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd37;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'd0;
        for (int c = 0; c < 25; c++) begin
            if (done) begin
                dones++;
                res = bcd;
            end
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 1 || res !== 12'h037 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL start_while_busy: done_pulses=%0d bcd=%h busy=%b expected 1 037 0", dones, res, busy);
        end
    endtask

    // start held high: results 9 cycles apart, old result held meanwhile.
    task automatic test_back_to_back();
        int cycles, gap;
        logic held_ok;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd45;
        @(negedge clk);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        tests_run++;
        if (done !== 1'b1 || bcd !== 12'h045) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: done=%b bcd=%h expected 1 045", done, bcd);
        end
        bin     = 8'd128;
        gap     = 0;
        held_ok = 1'b1;
        @(negedge clk);
        gap = 1;
        bin = 8'($urandom);
        while (!done && gap < 20) begin
            if (bcd !== 12'h045) held_ok = 1'b0;
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        tests_run++;
        if (gap !== 9 || bcd !== 12'h128 || held_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: gap=%0d bcd=%h held=%b expected 9 128 1", gap, bcd, held_ok);
        end
        @(negedge clk);
    endtask

    // Reset in the middle of SHIFT aborts with no done; the next run works.
    task automatic test_reset_mid();
        int dones, lat, bc;
        logic [11:0] res;
        logic bd;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd255;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 4; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, bcd} !== 14'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: busy=%b done=%b bcd=%h expected 0 0 000", busy, done, bcd);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_nodone: done_pulses=%0d expected 0", dones);
        end
        run_conversion(8'd12, lat, bc, res, bd);
        tests_run++;
        if (lat !== 8 || res !== 12'h012) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_after: latency=%0d bcd=%h expected 8 012", lat, res);
        end
    endtask

    // Test sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_sweep();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
